error_diffusion_row_engine: RTL and testbench
=============================================

# error_diffusion_row_engine

Streaming wrapper that drives one `error_diffusion_kernel` at one pixel per clock. It holds the previous-row error line buffer, registers the left and bottom error terms between adjacent pixels, and writes the accumulated errors back for the next row. It sits between the linear-space pixel source and the output pixel packer, with valid/ready handshakes on both sides.

## Interface
- `INPUT_BITS`, 8, input pixel width (kernel supports 8 only)
- `OUTPUT_BITS`, 4, dithered output width (1 or 4)
- `ERROR_BITS`, 9, signed error width in 10p1 fixed point (9 only)
- `MAX_WIDTH`, 1600, maximum pixels per row; line-buffer depth
- `ADDR_BITS`, 11, column counter width; ≥ $clog2(MAX_WIDTH)
- `clk`  in  1  sole clock
- `rstn`  in  1  asynchronous, active-low reset
- `s_pixel`  in  INPUT_BITS  linear input pixel
- `s_sof`  in  1  first pixel of frame
- `s_eol`  in  1  last pixel of row
- `s_valid`  in  1  input beat valid
- `s_ready`  out  1  input beat accepted when `s_valid && s_ready`
- `m_pixel`  out  OUTPUT_BITS  dithered pixel
- `m_sof`, `m_eol`  out  1 each  sideband delayed with the pixel
- `m_valid`  out  1  output beat valid
- `m_ready`  in  1  downstream accepts output

## Operation
- Two-stage pipeline with global advance `en = !m_valid || m_ready`; `s_ready = en` (combinational).
- Stage 0, on accept: register pixel, sof, eol, and column `x`; issue line-buffer read at `x` with read enable `en`, so read data holds during a stall.
- Column counter:
  - `x` = 0 on `s_sof`, or after an accepted beat with eol.
  - Otherwise increments.
  - A beat at `x == MAX_WIDTH-1` is treated as eol even if `s_eol` is low.
- Stage 1 feeds the kernel:
  - pixel;
  - `err_line_buffer_in` = read data, forced to 0 while `first_row` is set;
  - `err_left_in` = `r_left`;
  - `err_bottom_in` = `r_br`;
  - `err_bottom_left_in` = `r_b`.
- On stage-1 fire (`en && s1_valid`):
  - Register `m_pixel`, `m_sof`, `m_eol`, and set `m_valid`.
  - Update `r_left` ← `err_right_out`, `r_b` ← `err_bottom_out`, `r_br` ← `err_bottom_right_out`.
  - If `x > 0`, write `err_bottom_left_out` to buffer address `x-1`. At `x == 0` the bottom-left error is discarded (left image edge).
- Row end (stage-1 eol fires):
  - Latch `err_bottom_out` into a pending-write register. It is written to address `x` in the next clock, unconditionally; the port is free because the next pixel has `x == 0`.
  - Discard `err_bottom_right_out` (right image edge).
  - Clear `r_left`, `r_b`, `r_br` to 0.
- Pixel with `s_sof` at stage 1: `r_left`, `r_b`, `r_br` are taken as 0 for that pixel.
- `first_row`:
  - Set by reset and by stage-1 sof; cleared by stage-1 eol of that row.
  - Masks stale buffer contents from a previous frame, or from before reset.
- Line buffer: simple dual-port inferred RAM, `MAX_WIDTH` x `ERROR_BITS`, one read and one write port, never reset.
- No read/write hazard: reads at `x` precede the write of `x`, which happens when `x+1` processes or at row flush.
- A row of width 1 is legal: no bottom-left write; pending write goes to address 0.

## Timing
- Beat accepted at cycle N appears on `m_*` with `m_valid` at N+2 with no backpressure; throughput is 1 pixel/clock.
- `m_ready` low: `m_*` hold, `s_ready` low, RAM read data and all error registers hold; no beat lost or duplicated.
- Reset values:
  - `m_valid`, `m_pixel`, `m_sof`, `m_eol`, stage valids, error registers, pending-write flag, `x`: 0.
  - `first_row`: 1.
- Reset mid-row drops in-flight beats. The next frame must begin with `s_sof`.

## Test plan
- `OUTPUT_BITS=1`, sof row of width 4, all 128, `m_ready=1` → `m_pixel` 1,0,1,0 at accept+2 each; eol on 4th.
- `OUTPUT_BITS=1`, 3-row frame, all pixels 255 then all 0 → outputs all 1 then all 0; every buffer write equals 0.
- Width-4 all-128 stream, `m_ready` low 5 cycles mid-row → `m_pixel` stable, `s_ready` low, final sequence still 1,0,1,0.
- Row of random data, then new `s_sof` with the same all-128 row → 1,0,1,0 (previous-row error ignored).
- `rstn` pulsed low during pixel 2 of a row → `m_valid` 0 immediately; subsequent sof all-128 row gives 1,0,1,0.
- `OUTPUT_BITS=4`, width `MAX_WIDTH` with no `s_eol` → `m_eol` asserted on pixel `MAX_WIDTH-1`; next beat uses `x=0`.

Source files
------------

// File: rtl/error_diffusion_row_engine.sv
// Streaming Floyd-Steinberg row engine: one pixel per clock through a single
// combinational error_diffusion_kernel, with a previous-row error line buffer.

module error_diffusion_kernel #(
    parameter int INPUT_BITS  = 8,
    parameter int OUTPUT_BITS = 4,
    parameter int ERROR_BITS  = 9
) (
    input  logic        [INPUT_BITS-1:0]  pixel,
    input  logic signed [ERROR_BITS-1:0]  err_line_buffer_in,
    input  logic signed [ERROR_BITS-1:0]  err_left_in,
    input  logic signed [ERROR_BITS-1:0]  err_bottom_in,
    input  logic signed [ERROR_BITS-1:0]  err_bottom_left_in,
    output logic        [OUTPUT_BITS-1:0] pixel_out,
    output logic signed [ERROR_BITS-1:0]  err_right_out,
    output logic signed [ERROR_BITS-1:0]  err_bottom_left_out,
    output logic signed [ERROR_BITS-1:0]  err_bottom_out,
    output logic signed [ERROR_BITS-1:0]  err_bottom_right_out
);
    // Errors carry one fractional bit, so all arithmetic here is in half-units.
    localparam int SW      = ERROR_BITS + 4;
    localparam int QW      = SW + OUTPUT_BITS;
    localparam int LEVELS  = (1 << OUTPUT_BITS) - 1;
    localparam int PIX_MAX = (1 << INPUT_BITS) - 1;
    localparam logic signed [SW-1:0] V_MAX      = SW'(2 * PIX_MAX);
    localparam logic signed [SW-1:0] RECON_STEP = SW'(2 * (PIX_MAX / LEVELS));
    localparam logic signed [SW-1:0] E_MAX      = SW'((1 << (ERROR_BITS - 1)) - 1);
    localparam logic signed [SW-1:0] E_MIN      = SW'(-(1 << (ERROR_BITS - 1)));

    function automatic logic signed [ERROR_BITS-1:0] sat_err(input logic signed [SW-1:0] v);
        if (v > E_MAX) return E_MAX[ERROR_BITS-1:0];
        if (v < E_MIN) return E_MIN[ERROR_BITS-1:0];
        return v[ERROR_BITS-1:0];
    endfunction

    // k/16 share of an error, rounded half-up.
    function automatic logic signed [SW-1:0] weight(input logic signed [ERROR_BITS-1:0] e,
                                                    input logic signed [SW-1:0] k);
        logic signed [SW-1:0] p;
        p = SW'(e) * k + SW'(8);
        return p >>> 4;
    endfunction

    logic signed [SW-1:0]         sum;
    logic signed [SW-1:0]         v;
    logic signed [SW-1:0]         recon;
    logic signed [QW-1:0]         q;
    logic signed [ERROR_BITS-1:0] e;

    always_comb begin
        sum = SW'($signed({1'b0, pixel, 1'b0})) + SW'(err_line_buffer_in) + SW'(err_left_in);
        if (sum < 0)          v = '0;
        else if (sum > V_MAX) v = V_MAX;
        else                  v = sum;
        q                    = QW'(v) * QW'(LEVELS) + QW'(PIX_MAX + 1);
        pixel_out            = OUTPUT_BITS'(q >>> (INPUT_BITS + 1));
        recon                = $signed(SW'(pixel_out)) * RECON_STEP;
        e                    = sat_err(v - recon);
        err_right_out        = sat_err(weight(e, SW'(7)));
        err_bottom_left_out  = sat_err(SW'(err_bottom_left_in) + weight(e, SW'(3)));
        err_bottom_out       = sat_err(SW'(err_bottom_in) + weight(e, SW'(5)));
        err_bottom_right_out = sat_err(weight(e, SW'(1)));
    end
endmodule

module error_diffusion_row_engine #(
    parameter int INPUT_BITS  = 8,
    parameter int OUTPUT_BITS = 4,
    parameter int ERROR_BITS  = 9,
    parameter int MAX_WIDTH   = 1600,
    parameter int ADDR_BITS   = 11
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [INPUT_BITS-1:0]  s_pixel,
    input  logic                   s_sof,
    input  logic                   s_eol,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic [OUTPUT_BITS-1:0] m_pixel,
    output logic                   m_sof,
    output logic                   m_eol,
    output logic                   m_valid,
    input  logic                   m_ready
);
    localparam logic [ADDR_BITS-1:0] LAST_COL = ADDR_BITS'(MAX_WIDTH - 1);

    logic                         en, acc, fire_p1, eol_in;
    logic [ADDR_BITS-1:0]         x, col;
    logic [INPUT_BITS-1:0]        pix_p1;
    logic                         sof_p1, eol_p1, vld_p1;
    logic [ADDR_BITS-1:0]         x_p1;
    logic signed [ERROR_BITS-1:0] rd_data_p1;
    logic signed [ERROR_BITS-1:0] line_buf [MAX_WIDTH];
    logic                         first_row;
    logic signed [ERROR_BITS-1:0] r_left, r_b, r_br;
    logic                         pend_vld;
    logic [ADDR_BITS-1:0]         pend_addr;
    logic signed [ERROR_BITS-1:0] pend_data;
    logic signed [ERROR_BITS-1:0] lb_in, left_in, bot_in, bl_in;
    logic [OUTPUT_BITS-1:0]       k_pix;
    logic signed [ERROR_BITS-1:0] k_right, k_bl, k_bot, k_br;
    logic                         wr_en;
    logic [ADDR_BITS-1:0]         wr_addr;
    logic signed [ERROR_BITS-1:0] wr_data;

    assign en      = !m_valid || m_ready;
    assign s_ready = en;
    assign acc     = s_valid && en;
    assign col     = s_sof ? '0 : x;
    assign eol_in  = s_eol || (col == LAST_COL);
    assign fire_p1 = en && vld_p1;

    // ---- stage 0: accept beat, track column, read previous-row error ----
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            x      <= '0;
            vld_p1 <= 1'b0;
        end else if (en) begin
            vld_p1 <= s_valid;
            if (s_valid) x <= eol_in ? '0 : col + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (acc) begin
            pix_p1 <= s_pixel;
            sof_p1 <= s_sof;
            eol_p1 <= eol_in;
            x_p1   <= col;
        end
    end

    always_ff @(posedge clk) begin
        if (en) rd_data_p1 <= line_buf[col];
        if (wr_en) line_buf[wr_addr] <= wr_data;
    end

    // ---- stage 1: kernel, error propagation, buffer write-back ----
    always_comb begin
        lb_in   = (first_row || sof_p1) ? '0 : rd_data_p1;
        left_in = sof_p1 ? '0 : r_left;
        bot_in  = sof_p1 ? '0 : r_br;
        bl_in   = sof_p1 ? '0 : r_b;
        wr_en   = 1'b0;
        wr_addr = x_p1 - 1'b1;
        wr_data = k_bl;
        // A pending row-end write never collides: the following pixel sits at column 0.
        if (pend_vld) begin
            wr_en   = 1'b1;
            wr_addr = pend_addr;
            wr_data = pend_data;
        end else if (fire_p1 && x_p1 != '0) begin
            wr_en   = 1'b1;
        end
    end

    error_diffusion_kernel #(
        .INPUT_BITS (INPUT_BITS),
        .OUTPUT_BITS(OUTPUT_BITS),
        .ERROR_BITS (ERROR_BITS)
    ) u_kernel (
        .pixel               (pix_p1),
        .err_line_buffer_in  (lb_in),
        .err_left_in         (left_in),
        .err_bottom_in       (bot_in),
        .err_bottom_left_in  (bl_in),
        .pixel_out           (k_pix),
        .err_right_out       (k_right),
        .err_bottom_left_out (k_bl),
        .err_bottom_out      (k_bot),
        .err_bottom_right_out(k_br)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_valid   <= 1'b0;
            m_pixel   <= '0;
            m_sof     <= 1'b0;
            m_eol     <= 1'b0;
            r_left    <= '0;
            r_b       <= '0;
            r_br      <= '0;
            pend_vld  <= 1'b0;
            first_row <= 1'b1;
        end else begin
            pend_vld <= fire_p1 && eol_p1;
            if (en) m_valid <= vld_p1;
            if (fire_p1) begin
                m_pixel <= k_pix;
                m_sof   <= sof_p1;
                m_eol   <= eol_p1;
                if (eol_p1) begin
                    r_left    <= '0;
                    r_b       <= '0;
                    r_br      <= '0;
                    first_row <= 1'b0;
                end else begin
                    r_left <= k_right;
                    r_b    <= k_bot;
                    r_br   <= k_br;
                    if (sof_p1) first_row <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fire_p1 && eol_p1) begin
            pend_data <= k_bot;
            pend_addr <= x_p1;
        end
    end
endmodule

// File: tb/tb_error_diffusion_row_engine.sv
// Scoreboard bench for error_diffusion_row_engine (1-bit output, 12-pixel line buffer).

module tb_error_diffusion_row_engine;
    localparam int MAXW = 12;

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] s_pixel;
    logic       s_sof, s_eol, s_valid, s_ready;
    logic [0:0] m_pixel;
    logic       m_sof, m_eol, m_valid, m_ready;

    error_diffusion_row_engine #(
        .INPUT_BITS (8),
        .OUTPUT_BITS(1),
        .ERROR_BITS (9),
        .MAX_WIDTH  (MAXW),
        .ADDR_BITS  (4)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .s_pixel(s_pixel),
        .s_sof  (s_sof),
        .s_eol  (s_eol),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .m_pixel(m_pixel),
        .m_sof  (m_sof),
        .m_eol  (m_eol),
        .m_valid(m_valid),
        .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        dc;
        logic        pix;
        logic        sof;
        logic        eol;
        logic        lat;
        logic [31:0] acc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: one transfer per negedge with m_valid && m_ready.
    always @(negedge clk) begin
        if (rstn && m_valid && m_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got pixel %0d with empty scoreboard", m_pixel);
            end else begin
                mon_e = sb_q.pop_front();
                if (!mon_e.dc) check("m_pixel", 32'(m_pixel), 32'(mon_e.pix));
                check("m_sof", 32'(m_sof), 32'(mon_e.sof));
                check("m_eol", 32'(m_eol), 32'(mon_e.eol));
                if (mon_e.lat) check("latency", 32'(cyc) - mon_e.acc, 32'd2);
            end
        end
    end

    task automatic send(input logic [7:0] px, input logic sof, input logic eol,
                        input logic ep, input logic ee, input logic lat);
        bit ok = 1'b0;
        s_pixel = px;
        s_sof   = sof;
        s_eol   = eol;
        s_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (s_ready) begin
                sb_q.push_back('{dc: 1'b0, pix: ep, sof: sof, eol: ee, lat: lat, acc: 32'(cyc)});
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got s_ready 0 for 64 cycles, expected 1");
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_eol   = 1'b0;
    endtask

    // bits[i] is the expected output of pixel i; m_eol is expected on the last pixel.
    task automatic send_row(input logic [7:0] px, input int w, input logic sof,
                            input logic use_eol, input logic [11:0] bits, input logic lat);
        for (int i = 0; i < w; i++)
            send(px, sof && (i == 0), use_eol && (i == w - 1), bits[i], i == w - 1, lat);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain_left", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    task automatic stall5();
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_s_ready", 32'(s_ready), 32'd0);
            check("stall_m_valid", 32'(m_valid), 32'd1);
            check("stall_m_pixel", 32'(m_pixel), 32'd1);
            check("stall_m_sof", 32'(m_sof), 32'd1);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected end of run");
        $fatal(1);
    end

    initial begin
        rstn    = 1'b0;
        s_pixel = '0;
        s_sof   = 1'b0;
        s_eol   = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_pixel", 32'(m_pixel), 32'd0);
        check("rst_m_sof", 32'(m_sof), 32'd0);
        check("rst_m_eol", 32'(m_eol), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd1);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Mid-grey first row dithers to 1,0,1,0, two cycles after each accept.
        send_row(8'd128, 4, 1'b1, 1'b1, 12'h005, 1'b1);
        drain();

        // White row then two black rows: zero error everywhere.
        send_row(8'd255, 4, 1'b1, 1'b1, 12'h00F, 1'b0);
        send_row(8'd0,   4, 1'b0, 1'b1, 12'h000, 1'b0);
        send_row(8'd0,   4, 1'b0, 1'b1, 12'h000, 1'b0);
        drain();

        // Five-cycle backpressure while pixel 0 sits on the output.
        send(8'd128, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        send(8'd128, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        fork
            stall5();
            begin
                send(8'd128, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
                send(8'd128, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
            end
        join
        drain();

        // Bright row leaves negative errors; the next sof row must ignore them.
        send_row(8'd200, 4, 1'b1, 1'b1, 12'h00F, 1'b0);
        send_row(8'd128, 4, 1'b1, 1'b1, 12'h005, 1'b0);
        drain();

        // Reset while pixel 2 of a row is in flight.
        send(8'd128, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        send(8'd128, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        s_pixel = 8'd128;
        s_valid = 1'b1;
        @(posedge clk);
        #1;
        rstn    = 1'b0;
        s_valid = 1'b0;
        sb_q.delete();
        #1;
        check("midrst_m_valid", 32'(m_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("midrst_hold_m_valid", 32'(m_valid), 32'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        send_row(8'd128, 4, 1'b1, 1'b1, 12'h005, 1'b0);
        drain();

        // Single-pixel row.
        send_row(8'd128, 1, 1'b1, 1'b1, 12'h001, 1'b0);
        drain();

        // Full-width rows without s_eol: eol forced on the last column, next row restarts at 0.
        send_row(8'd255, MAXW, 1'b1, 1'b0, 12'hFFF, 1'b0);
        send_row(8'd0,   MAXW, 1'b0, 1'b0, 12'h000, 1'b0);
        send_row(8'd128, 4,    1'b1, 1'b1, 12'h005, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
